// File: rtl/fu_result_buf_pkg.sv
// ----------------------------------------------------------------------------
// fu_result_buf_pkg: helpers shared by the circular queues in the core.
//   ptr_inc(ptr, depth) - advance a queue pointer, wrapping from depth-1 to 0
//                         by explicit compare so non-power-of-two depths work.
// ----------------------------------------------------------------------------
package fu_result_buf_pkg;

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs: system-wide type definitions shared across the pipeline.
//   FU_PACKET            - result record produced by a functional unit
//   FU_BUF_DEPTH_DEFAULT - default depth of FU result buffers, taken from
//                          the FU_BUF_DEPTH macro (4 when not overridden)
// ----------------------------------------------------------------------------
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`ifndef FU_BUF_DEPTH
`define FU_BUF_DEPTH 4
`endif

package sys_defs;

    localparam int unsigned FU_BUF_DEPTH_DEFAULT = `FU_BUF_DEPTH;

    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  dest_tag;
        logic [4:0]  rob_idx;
    } FU_PACKET;

endpackage

`endif

// File: rtl/fu_result_buf.sv
// ----------------------------------------------------------------------------
// fu_result_buf: in-order result queue between a pipelined FU and the CDB.
//
// Captures each FU result presented with data_ready, holds it in a DEPTH-entry
// circular buffer and offers the oldest entry to the CDB under req/gnt.
// stall back-pressures the FU when the buffer is full.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high
//   fu_pack     result presented by the FU
//   data_ready  fu_pack valid this cycle
//   squash      flush all buffered and incoming results
//   stall       to FU: buffer full, hold the presented result
//   cdb_req     head entry valid, requesting the CDB
//   cdb_pack    head entry contents
//   cdb_gnt     CDB accepts cdb_pack this cycle
//   count       occupancy
//
// Build option: define FU_RESULT_BUF_BYPASS_EN to forward fu_pack straight to
// the CDB when the buffer is empty (zero-cycle latency).
// ----------------------------------------------------------------------------
module fu_result_buf
    import sys_defs::*;
    import fu_result_buf_pkg::*;
#(
    parameter int unsigned DEPTH = FU_BUF_DEPTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  FU_PACKET                     fu_pack,
    input  logic                         data_ready,
    input  logic                         squash,
    output logic                         stall,
    output logic                         cdb_req,
    output FU_PACKET                     cdb_pack,
    input  logic                         cdb_gnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    FU_PACKET         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;
    logic             bypass_take;

    // Registered state only: no path from cdb_gnt or data_ready.
    assign stall = (count == CNT_W'(DEPTH));

    always_comb begin
        bypass_take = 1'b0;
        cdb_req     = (count != '0);
        cdb_pack    = mem[head];
`ifdef FU_RESULT_BUF_BYPASS_EN
        if ((count == '0) && data_ready && !squash) begin
            cdb_req     = 1'b1;
            cdb_pack    = fu_pack;
            bypass_take = cdb_gnt;
        end
`endif
        enq = data_ready && !stall && !squash && !bypass_take;
        // Dequeue only from storage; a bypass grant never touches head.
        deq = (count != '0) && cdb_gnt && !squash;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                mem[tail] <= fu_pack;
                tail      <= PTR_W'(ptr_inc(32'(tail), DEPTH));
            end
            if (deq) begin
                head <= PTR_W'(ptr_inc(32'(head), DEPTH));
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_result_buf.sv
`timescale 1ns/1ps
module tb_fu_result_buf;
    import sys_defs::*;

    localparam int unsigned D  = 4;
    localparam int unsigned D3 = 3;
`ifdef FU_RESULT_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance, DEPTH=4
    logic reset = 1'b1, data_ready = 1'b0, squash = 1'b0, cdb_gnt = 1'b0;
    logic stall, cdb_req;
    FU_PACKET fu_pack = '0;
    FU_PACKET cdb_pack;
    logic [$clog2(D+1)-1:0] count;

    // second instance, DEPTH=3 (pointer wrap at non-power-of-two depth)
    logic reset3 = 1'b1, data_ready3 = 1'b0, squash3 = 1'b0, cdb_gnt3 = 1'b0;
    logic stall3, cdb_req3;
    FU_PACKET fu_pack3 = '0;
    FU_PACKET cdb_pack3;
    logic [$clog2(D3+1)-1:0] count3;

    fu_result_buf #(.DEPTH(D)) u_dut (
        .clock(clock), .reset(reset), .fu_pack(fu_pack), .data_ready(data_ready),
        .squash(squash), .stall(stall), .cdb_req(cdb_req), .cdb_pack(cdb_pack),
        .cdb_gnt(cdb_gnt), .count(count)
    );

    fu_result_buf #(.DEPTH(D3)) u_dut3 (
        .clock(clock), .reset(reset3), .fu_pack(fu_pack3), .data_ready(data_ready3),
        .squash(squash3), .stall(stall3), .cdb_req(cdb_req3), .cdb_pack(cdb_pack3),
        .cdb_gnt(cdb_gnt3), .count(count3)
    );

    int errors = 0;
    int checks = 0;
    int unsigned max_count;

    FU_PACKET model_q[$];   // expected buffer contents, oldest first
    FU_PACKET fu_src[$];    // results the FU still has to hand over
    FU_PACKET q3[$];

    function automatic FU_PACKET mk(input int unsigned v);
        FU_PACKET p;
        p.result   = v;
        p.dest_tag = 6'(v * 7);
        p.rob_idx  = 5'(v + 3);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the main instance. The FU side re-presents its oldest
    // pending result until the buffer accepts it.
    task automatic cycle(input logic r, input logic sq, input logic want_gnt);
        int unsigned sz;
        logic dr, byp, exp_req, g;
        @(negedge clock);
        dr         = (fu_src.size() != 0);
        reset      = r;
        squash     = sq;
        data_ready = dr;
        fu_pack    = dr ? fu_src[0] : mk(32'hdead);
        cdb_gnt    = 1'b0;
        #1;
        sz      = model_q.size();
        byp     = BYP && (sz == 0) && dr && !sq;
        exp_req = (sz != 0) || byp;
        chk("count", 64'(count), 64'(sz));
        chk("stall", 64'(stall), 64'(sz == D));
        chk("cdb_req", 64'(cdb_req), 64'(exp_req));
        if (exp_req)
            chk("cdb_pack", 64'(cdb_pack), 64'((sz != 0) ? model_q[0] : fu_src[0]));
        cdb_gnt = want_gnt & cdb_req;
        g = cdb_gnt;
        if (r || sq) begin
            model_q.delete();
            fu_src.delete();
        end else if (byp && g) begin
            void'(fu_src.pop_front());
        end else begin
            if (g && sz != 0) void'(model_q.pop_front());
            if (dr && sz < D) model_q.push_back(fu_src.pop_front());
        end
        if (model_q.size() > max_count) max_count = model_q.size();
        @(posedge clock);
    endtask

    // One clock of the DEPTH=3 instance (never granted while empty).
    task automatic cycle3(input logic dr, input logic g, input int unsigned v);
        @(negedge clock);
        reset3      = 1'b0;
        data_ready3 = dr;
        fu_pack3    = mk(v);
        cdb_gnt3    = 1'b0;
        #1;
        chk("d3_count", 64'(count3), 64'(q3.size()));
        chk("d3_stall", 64'(stall3), 64'(q3.size() == D3));
        if (q3.size() != 0) chk("d3_pack", 64'(cdb_pack3), 64'(q3[0]));
        cdb_gnt3 = g & cdb_req3;
        if (cdb_gnt3 && q3.size() != 0) void'(q3.pop_front());
        if (dr) q3.push_back(mk(v));
        @(posedge clock);
    endtask

    // Protocol invariants on the main instance
    always @(posedge clock) begin
        if (!reset) begin
            checks += 3;
            assert (count <= D) else begin
                errors++;
                $display("FAIL inv_count: got %0d max %0d", count, D);
            end
            assert (!(cdb_gnt && !cdb_req)) else begin
                errors++;
                $display("FAIL inv_gnt: gnt=%b req=%b", cdb_gnt, cdb_req);
            end
            assert (!(stall && count < D)) else begin
                errors++;
                $display("FAIL inv_stall: stall=%b count=%0d", stall, count);
            end
        end
    end

    typedef struct {
        logic        r;
        logic        sq;
        logic        gnt;
        logic        push;
        int unsigned val;
        int unsigned exp_count;
        logic        exp_stall;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // fill with grant low, hold the 5th result, full+grant, drain
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 4, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 4, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};

        max_count = 0;
        // bring both instances out of the unknown power-up state
        @(posedge clock);
        @(posedge clock);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].push) fu_src.push_back(mk(tbl[i].val));
            cycle(tbl[i].r, tbl[i].sq, tbl[i].gnt);
            #1;
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_stall", 64'(stall), 64'(tbl[i].exp_stall));
            if (tbl[i].r) begin
                chk("rst_req", 64'(cdb_req), 64'(0));
                chk("rst_pack", 64'(cdb_pack), 64'(0));
            end
        end

        // A,B,C back to back with grant always high
        max_count = 0;
        fu_src.push_back(mk(32'hA));
        fu_src.push_back(mk(32'hB));
        fu_src.push_back(mk(32'hC));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("abc_maxcount_le1", 64'(max_count <= 1), 64'(1));

        // squash at count=3 with a result incoming and a grant
        for (int i = 0; i < 3; i++) begin
            fu_src.push_back(mk(32'h30 + i));
            cycle(1'b0, 1'b0, 1'b0);
        end
        fu_src.push_back(mk(32'h5a5a));
        cycle(1'b0, 1'b1, 1'b1);
        #1;
        chk("sq_count", 64'(count), 64'(0));
        chk("sq_req", 64'(cdb_req), 64'(0));
        fu_src.push_back(mk(32'h40));
        fu_src.push_back(mk(32'h41));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);

        // reset with two entries held
        for (int i = 0; i < 2; i++) begin
            fu_src.push_back(mk(32'h50 + i));
            cycle(1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b1);
        #1;
        chk("mrst_count", 64'(count), 64'(0));
        chk("mrst_stall", 64'(stall), 64'(0));
        chk("mrst_req", 64'(cdb_req), 64'(0));
        chk("mrst_pack", 64'(cdb_pack), 64'(0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        fu_src.push_back(mk(32'h60));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // wrap on DEPTH=3: hold count at 2 across 10 enqueue/dequeue pairs
        @(negedge clock);
        reset3 = 1'b1;
        @(posedge clock);
        q3.delete();
        cycle3(1'b1, 1'b0, 200);
        cycle3(1'b1, 1'b0, 201);
        for (int k = 0; k < 10; k++) begin
            cycle3(1'b1, 1'b1, 202 + k);
            #1;
            chk("d3_wrap_count", 64'(count3), 64'(2));
        end
        for (int k = 0; k < 3; k++) cycle3(1'b0, 1'b1, 0);
        chk("d3_drained", 64'(q3.size()), 64'(0));

        // randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic r, sq, g;
            if ($urandom_range(0, 1) == 1 && fu_src.size() < 2)
                fu_src.push_back(mk($urandom));
            r  = ($urandom_range(0, 99) == 0);
            sq = ($urandom_range(0, 39) == 0);
            g  = (n < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            cycle(r, sq, g);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("final_empty", 64'(count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_result_buf.md
Name: fu_result_buf

Overview:
- Sits between a pipelined functional unit (e.g. the multiplier) and the CDB/complete stage.
- Captures each FU_PACKET the FU presents with data_ready and holds it in a small in-order queue.
- Drives results onto the CDB under a request/grant handshake.
- Back-pressures the FU through stall, so no result is lost while the CDB is busy.

Parameters:
- DEPTH, 4: number of buffered results; legal values are 2..16, and non-power-of-two values are legal.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fu_pack  in  $bits(FU_PACKET)  result presented by the FU
- data_ready  in  1  fu_pack is a valid result this cycle
- squash  in  1  mispredict flush; discard all buffered and incoming results
- stall  out  1  to FU: freeze pipeline and hold the presented result
- cdb_req  out  1  head entry valid, requesting the CDB
- cdb_pack  out  $bits(FU_PACKET)  head entry contents
- cdb_gnt  in  1  CDB accepts cdb_pack this cycle; only meaningful when cdb_req=1
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset values: stall=0, cdb_req=0, cdb_pack='0, count=0, head=tail=0, all storage cleared.
- Reset is taken at the clock edge and overrides every other input.
- Storage is a circular buffer of DEPTH FU_PACKET entries with head and tail pointers.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by bit overflow.
- stall = (count == DEPTH). It is combinational from registered state only; there is no path from cdb_gnt or data_ready.
- Enqueue condition: data_ready && !stall && !squash.
  - fu_pack is written at tail and tail advances.
  - While stall=1 the FU holds data_ready and fu_pack constant, so the result is re-presented and enqueued on the first cycle stall=0.
- Dequeue condition: cdb_req && cdb_gnt && !squash. Head advances.
- cdb_req = (count != 0). cdb_pack = entry[head].
- Latency: a result enqueued at edge N is requested from cycle N+1.
- Enqueue and dequeue in the same cycle: both pointers advance and count is unchanged.
  - This is legal at any count below DEPTH, including count==1.
- Full with a grant: stall is already asserted, so there is no enqueue that cycle and count drops to DEPTH-1.
  - stall deasserts the next cycle.
- Empty: cdb_req=0, and cdb_gnt is ignored.
- Order is strictly FIFO. Every enqueued result appears on cdb_pack exactly once.
- squash (priority below reset, above all else):
  - At the next edge: count=0, head=tail=0, and the incoming result is dropped even if data_ready=1.
  - An outstanding grant that cycle is ignored.
  - Storage contents need not be cleared.
- Assertions for the bench:
  - count never exceeds DEPTH.
  - cdb_gnt is never high while cdb_req=0.
  - stall never asserts while count<DEPTH.

Optional Feature:
- FU_RESULT_BUF_BYPASS_EN defined:
  - When count==0 and data_ready=1, cdb_req=1 and cdb_pack=fu_pack combinationally.
  - If cdb_gnt is also high, the result is consumed and not written; count stays 0.
  - Otherwise it is enqueued normally.
  - squash suppresses the bypass request.
  - Zero-cycle latency when empty.
- Not defined: there is no combinational path from fu_pack to cdb_pack, and the minimum latency is 1 cycle.

Decomposition:
- FU_PACKET and any DEPTH default macro (FU_BUF_DEPTH) live in sys_defs.
- The pointer-increment-with-wrap function goes in a shared package, since other queues reuse it.
- No sub-module is needed: storage, pointers and count fit in one module.

Test Plan:
- Reset, then 3 results A,B,C on consecutive cycles with cdb_gnt=1 always -> cdb_pack A,B,C on cycles 1,2,3 (cycles 0,1,2 with BYPASS_EN); count never exceeds 1; stall stays 0.
- cdb_gnt=0, feed 5 results with DEPTH=4 -> count reaches 4, stall=1 on the cycle after the 4th enqueue; 5th result held and enqueued on the cycle after the first grant; drain order 1..5.
- Full, with data_ready=1 and cdb_gnt=1 in the same cycle -> no enqueue; count goes 4->3; next cycle stall=0 and enqueue brings count back to 4.
- Wrap: 10 enqueue/dequeue pairs at count=2 with DEPTH=3 -> pointers wrap; output order is preserved and count stays 2.
- squash with count=3 and data_ready=1 -> next cycle count=0, cdb_req=0, and the incoming result never appears on cdb_pack.
- Reset asserted with count=2 and stall=0 -> next cycle all outputs at reset values; stale entries never re-emerge.
